// File: rtl/keccak_tx_pkg.sv
// Shared constants, state encoding and header helper for the Keccak result transmitter.
// Frame length depends on the KECCAK_TX_DIGEST_EN build macro.
package keccak_tx_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } tx_state_t;

    localparam int FRAME_LEN_BASE   = 3;
    localparam int FRAME_LEN_DIGEST = 11;

`ifdef KECCAK_TX_DIGEST_EN
    localparam int FRAME_LEN = FRAME_LEN_DIGEST;
`else
    localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

    // Wide enough to index every word of the longest frame.
    localparam int WORD_IDX_W = 4;

    localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(FRAME_LEN - 1);
    localparam logic [7:0]            LEN_BYTE = 8'(FRAME_LEN);

    function automatic logic [31:0] make_header(input logic [7:0] seq, input logic [7:0] drops);
        return {SYNC_BYTE, seq, drops, LEN_BYTE};
    endfunction

endpackage

// File: rtl/keccak_tx_pending.sv
// One-entry capture buffer for match events; digest storage exists only with KECCAK_TX_DIGEST_EN.
// A match that lands while the entry is being drained refills it instead of being dropped.
module keccak_tx_pending (
    input  logic         clk,
    input  logic         reset,
    input  logic         match_valid,
    input  logic [31:0]  match_nonce,
    input  logic [255:0] match_digest,
    input  logic         drain,
    output logic         full,
    output logic [31:0]  entry_nonce,
`ifdef KECCAK_TX_DIGEST_EN
    output logic [255:0] entry_digest,
`endif
    output logic         drop
);

    logic        full_q, full_d;
    logic [31:0] nonce_q, nonce_d;
    logic        capture;

`ifdef KECCAK_TX_DIGEST_EN
    logic [255:0] digest_q, digest_d;
`else
    logic unused_digest;
    assign unused_digest = ^match_digest;
`endif

    always_comb begin
        capture = match_valid & (~full_q | drain);
        drop    = match_valid & full_q & ~drain;
        full_d  = full_q;
        nonce_d = nonce_q;
`ifdef KECCAK_TX_DIGEST_EN
        digest_d = digest_q;
`endif
        if (drain) begin
            full_d = 1'b0;
        end
        if (capture) begin
            full_d  = 1'b1;
            nonce_d = match_nonce;
`ifdef KECCAK_TX_DIGEST_EN
            digest_d = match_digest;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q  <= 1'b0;
            nonce_q <= 32'h0;
`ifdef KECCAK_TX_DIGEST_EN
            digest_q <= 256'h0;
`endif
        end else begin
            full_q  <= full_d;
            nonce_q <= nonce_d;
`ifdef KECCAK_TX_DIGEST_EN
            digest_q <= digest_d;
`endif
        end
    end

    assign full        = full_q;
    assign entry_nonce = nonce_q;
`ifdef KECCAK_TX_DIGEST_EN
    assign entry_digest = digest_q;
`endif

endmodule

// File: rtl/keccak_result_tx.sv
// Streams buffered Keccak match events to the host as framed 32-bit words (KECCAK_TX_DIGEST_EN adds the digest).
// tx_valid rises only from LOAD and falls only on the checksum handshake; tx_data changes only on a handshake.
module keccak_result_tx
    import keccak_tx_pkg::*;
#(
    parameter int DROP_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         match_valid,
    input  logic [31:0]  match_nonce,
    input  logic [255:0] match_digest,
    output logic [31:0]  tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         tx_busy
);

    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    tx_state_t               state_q, state_d;
    logic [WORD_IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_IDX_W-1:0]   next_idx;
    logic [31:0]             tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic [31:0]             csum_q, csum_d;
    logic [31:0]             nonce_q, nonce_d;
    logic [7:0]              seq_q, seq_d;
    logic [DROP_W-1:0]       drops_q, drops_d;
    logic                    hs;
    logic                    drain;
    logic                    pend_full;
    logic                    pend_drop;
    logic [31:0]             pend_nonce;
    logic [31:0]             header;

`ifdef KECCAK_TX_DIGEST_EN
    logic [255:0] digest_q, digest_d;
    logic [255:0] pend_digest;
`endif

    keccak_tx_pending u_pending (
        .clk          (clk),
        .reset        (reset),
        .match_valid  (match_valid),
        .match_nonce  (match_nonce),
        .match_digest (match_digest),
        .drain        (drain),
        .full         (pend_full),
        .entry_nonce  (pend_nonce),
`ifdef KECCAK_TX_DIGEST_EN
        .entry_digest (pend_digest),
`endif
        .drop         (pend_drop)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        csum_d     = csum_q;
        nonce_d    = nonce_q;
        seq_d      = seq_q;
        drops_d    = drops_q;
`ifdef KECCAK_TX_DIGEST_EN
        digest_d   = digest_q;
`endif
        drain      = 1'b0;
        hs         = tx_valid_q & tx_ready;
        next_idx   = idx_q + WORD_IDX_W'(1);
        header     = make_header(seq_q, 8'(drops_q));

        if (pend_drop && drops_q != DROP_MAX) begin
            drops_d = drops_q + DROP_W'(1);
        end

        case (state_q)
            IDLE: begin
                // Jump on the capture itself so the header appears two cycles after the match.
                if (pend_full || match_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                drain      = 1'b1;
                tx_data_d  = header;
                csum_d     = header;
                tx_valid_d = 1'b1;
                idx_d      = '0;
                seq_d      = seq_q + 8'd1;
                nonce_d    = pend_nonce;
                drops_d    = DROP_W'(pend_drop);
`ifdef KECCAK_TX_DIGEST_EN
                digest_d   = pend_digest;
`endif
                state_d    = SEND;
            end
            SEND: begin
                if (hs) begin
                    if (idx_q == LAST_IDX) begin
                        tx_valid_d = 1'b0;
                        state_d    = (pend_full || match_valid) ? LOAD : IDLE;
                    end else begin
                        idx_d = next_idx;
                        // csum_q already folds in every word presented so far.
                        if (next_idx == LAST_IDX) begin
                            tx_data_d = csum_q;
                        end else if (next_idx == WORD_IDX_W'(1)) begin
                            tx_data_d = nonce_q;
                            csum_d    = csum_q ^ nonce_q;
                        end
`ifdef KECCAK_TX_DIGEST_EN
                        else begin
                            tx_data_d = digest_q[255:224];
                            csum_d    = csum_q ^ digest_q[255:224];
                            digest_d  = {digest_q[223:0], 32'h0};
                        end
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            tx_data_q  <= 32'h0;
            tx_valid_q <= 1'b0;
            csum_q     <= 32'h0;
            nonce_q    <= 32'h0;
            seq_q      <= 8'h0;
            drops_q    <= '0;
`ifdef KECCAK_TX_DIGEST_EN
            digest_q   <= 256'h0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            csum_q     <= csum_d;
            nonce_q    <= nonce_d;
            seq_q      <= seq_d;
            drops_q    <= drops_d;
`ifdef KECCAK_TX_DIGEST_EN
            digest_q   <= digest_d;
`endif
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_busy  = (state_q != IDLE) | pend_full;

endmodule
